// File: rtl/scroll_controller_if.sv
// Frame and collision signals between the video timing logic and the
// scroll sequencer. The sequencer sits on the slave side.
interface scroll_controller_if;
  logic        new_frame;
  logic        start_in;
  logic [10:0] x_center_mass;
  logic        collision_in;
  logic [11:0] offset_out;
  logic        collision_out;
  logic        done_out;
  logic [7:0]  hit_count_out;
  logic [1:0]  state_out;

  modport master (
    output new_frame, start_in, x_center_mass, collision_in,
    input  offset_out, collision_out, done_out, hit_count_out, state_out
  );

  modport slave (
    input  new_frame, start_in, x_center_mass, collision_in,
    output offset_out, collision_out, done_out, hit_count_out, state_out
  );
endinterface

// File: rtl/scroll_controller.sv
// Frame-rate scroll sequencer: advances the background offset once per frame,
// freezes for HIT_FRAMES frames after a collision and stops at the end of the map.
module scroll_controller #(
  parameter int MAX_OFFSET   = 2096,
  parameter int SLOW_STEP    = 1,
  parameter int FAST_STEP    = 4,
  parameter int LEFT_THRESH  = 320,
  parameter int RIGHT_THRESH = 960,
  parameter int HIT_FRAMES   = 60
) (
  input  logic               pixel_clk_in,
  input  logic               rst_n_in,
  scroll_controller_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCROLL = 2'd1,
    HIT    = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [12:0] MAX13 = 13'(MAX_OFFSET);

  state_t      state_q, state_d;
  logic [11:0] offset_q, offset_d;
  logic [7:0]  hit_count_q, hit_count_d;
  logic [7:0]  hit_left_q, hit_left_d;
  logic        sticky_q, sticky_d;
  logic        collision_q, collision_d;
  logic        done_q, done_d;

  logic [12:0] step_s;
  logic [12:0] sum_s;
  logic [11:0] next_offset_s;
  logic        frame_hit_s;

  // Step selection and saturating 13-bit advance so the sum cannot wrap
  always_comb begin
    step_s = 13'd0;
    if (bus.x_center_mass < 11'(LEFT_THRESH)) begin
      step_s = 13'd0;
    end else if (bus.x_center_mass > 11'(RIGHT_THRESH)) begin
      step_s = 13'(FAST_STEP);
    end else begin
      step_s = 13'(SLOW_STEP);
    end
    sum_s         = {1'b0, offset_q} + step_s;
    next_offset_s = (sum_s >= MAX13) ? MAX13[11:0] : sum_s[11:0];
    frame_hit_s   = sticky_q | bus.collision_in;
  end

  // Next-state and datapath decisions
  always_comb begin
    state_d     = state_q;
    offset_d    = offset_q;
    hit_count_d = hit_count_q;
    hit_left_d  = hit_left_q;
    if (bus.new_frame) begin
      sticky_d = 1'b0;
    end else if ((state_q == SCROLL) && bus.collision_in) begin
      sticky_d = 1'b1;
    end else begin
      sticky_d = sticky_q;
    end

    case (state_q)
      IDLE, DONE: begin
        if (bus.start_in) begin
          state_d     = SCROLL;
          offset_d    = 12'd0;
          hit_count_d = 8'd0;
          sticky_d    = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      SCROLL: begin
        if (bus.new_frame && frame_hit_s) begin
          state_d     = HIT;
          hit_count_d = (hit_count_q == 8'hFF) ? 8'hFF : hit_count_q + 8'd1;
          hit_left_d  = 8'(HIT_FRAMES);
        end else if (bus.new_frame) begin
          offset_d = next_offset_s;
          state_d  = (next_offset_s == MAX13[11:0]) ? DONE : SCROLL;
        end else begin
          state_d = SCROLL;
        end
      end
      HIT: begin
        if (bus.new_frame && (hit_left_q == 8'd1)) begin
          state_d = SCROLL;
        end else if (bus.new_frame) begin
          hit_left_d = hit_left_q - 8'd1;
        end else begin
          state_d = HIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    collision_d = (state_d == HIT);
    done_d      = (state_d == DONE);
  end

  // State and registered outputs
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= IDLE;
      offset_q    <= 12'd0;
      hit_count_q <= 8'd0;
      hit_left_q  <= 8'd0;
      sticky_q    <= 1'b0;
      collision_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      offset_q    <= offset_d;
      hit_count_q <= hit_count_d;
      hit_left_q  <= hit_left_d;
      sticky_q    <= sticky_d;
      collision_q <= collision_d;
      done_q      <= done_d;
    end
  end

  assign bus.offset_out    = offset_q;
  assign bus.state_out     = state_q;
  assign bus.collision_out = collision_q;
  assign bus.done_out      = done_q;
  assign bus.hit_count_out = hit_count_q;

endmodule

// File: doc/scroll_controller.md
# scroll_controller

Frame-rate scroll sequencer for the tile-map background. It produces the 12-bit horizontal `offset` consumed by the tile-index lookup and the collision flag consumed alongside it. The scroll position advances once per frame at a speed chosen from the player's horizontal centre of mass. The block freezes scrolling for a fixed number of frames after a collision and stops when the end of the map is reached. Offset changes only on the frame-start pulse, so it stays constant across the active video of a frame.

## Interface
Parameters:
- `MAX_OFFSET`, 2096: final scroll position in pixels (211 tiles × 16 − 1280); offset saturates here.
- `SLOW_STEP`, 1: pixels advanced per frame when the player is mid-screen.
- `FAST_STEP`, 4: pixels advanced per frame when the player is right of `RIGHT_THRESH`.
- `LEFT_THRESH`, 320: `x_center_mass` below this gives step 0.
- `RIGHT_THRESH`, 960: `x_center_mass` above this gives `FAST_STEP`.
- `HIT_FRAMES`, 60: number of frames scrolling is frozen after a collision; must be ≥1.

Ports:
- `pixel_clk_in`  in  1  sole clock.
- `rst_n_in`  in  1  asynchronous, active-low reset.
- `new_frame`  in  1  one-cycle pulse at frame start.
- `start_in`  in  1  level/pulse; begins or restarts a run.
- `x_center_mass`  in  11  player horizontal centroid in pixels, sampled on `new_frame`.
- `collision_in`  in  1  per-pixel collision indication, any cycle.
- `offset_out`  out  12  current scroll offset.
- `collision_out`  out  1  high while in HIT.
- `done_out`  out  1  high while in DONE.
- `hit_count_out`  out  8  collisions this run, saturating at 255.
- `state_out`  out  2  IDLE=0, SCROLL=1, HIT=2, DONE=3.

## Operation
- Reset (async assert, sync deassert by the caller): state IDLE. All outputs are 0, `hit_frames_left` is 0 and the sticky collision flag is 0.
- Sticky collision flag:
  - Set on any cycle with `collision_in`=1 while in SCROLL.
  - Cleared on every `new_frame` cycle.
  - A frame counts as collided when `sticky | collision_in` is true on its `new_frame` cycle.
- IDLE:
  - `start_in`=1 → SCROLL, with `offset_out`=0, `hit_count_out`=0 and the sticky flag cleared.
  - `new_frame` and collisions are ignored.
- SCROLL, on a `new_frame` cycle:
  - If the frame collided → HIT.
    - `offset_out` is unchanged.
    - `hit_count_out` += 1, saturating at 255.
    - `hit_frames_left` ← `HIT_FRAMES`.
  - Otherwise, the step is chosen from `x_center_mass`:
    - < `LEFT_THRESH` → 0.
    - > `RIGHT_THRESH` → `FAST_STEP`.
    - Otherwise → `SLOW_STEP`.
  - New offset = min(offset + step, `MAX_OFFSET`), computed 13 bits wide so it cannot wrap.
  - If the new offset equals `MAX_OFFSET` → DONE.
  - Collision has priority over reaching the end in the same frame.
- HIT:
  - `collision_in` is ignored; a collision does not extend the freeze.
  - On each `new_frame`:
    - If `hit_frames_left`==1 → SCROLL. The offset does not advance on this frame.
    - Otherwise `hit_frames_left` −= 1.
- DONE:
  - `offset_out` holds `MAX_OFFSET` and `done_out`=1.
  - `start_in`=1 → SCROLL, with offset 0 and hit_count 0.
- `start_in` is ignored in SCROLL and HIT.
- When `start_in` and `new_frame` coincide in IDLE or DONE, start wins and no step is applied that cycle.
- `collision_out` = (state==HIT). `done_out` = (state==DONE).

## Timing
- All outputs are registered.
- An update decided on the `new_frame` cycle N is visible at `offset_out`/`state_out` from cycle N+1.
- `offset_out` is constant between consecutive `new_frame` pulses.
- A collision at any cycle during frame k (between pulses k and k+1) freezes the offset at pulse k+1. `collision_out` rises the cycle after pulse k+1.
- The HIT freeze covers `HIT_FRAMES` pulses. The first advance happens at pulse k+1+`HIT_FRAMES`+1.
- Back-to-back `new_frame` pulses on consecutive cycles are each processed.
- Reset asserted mid-run returns to IDLE immediately, with all outputs 0 asynchronously.

## Test plan
1. Reset, then `start_in` pulse, then 10 frames with `x_center_mass`=640 → `offset_out` reads 1..10 after each pulse; `state_out`=1.
2. `x_center_mass`=100 for 5 frames, then 1000 for 5 frames → offset stays 0, then reaches 20.
3. Pulse `collision_in` for one cycle mid-frame at offset 50:
   - After the next pulse: `collision_out`=1, `hit_count_out`=1.
   - Offset stays 50 through 60 pulses, with a further collision during the freeze ignored.
   - The 61st pulse after the freeze ends gives offset 51 at `x_center_mass`=640.
4. Offset 2094 with `x_center_mass`=1000 → next pulse gives `offset_out`=2096, `done_out`=1, `state_out`=3. Further pulses leave it at 2096. `start_in` then resets it to 0 in SCROLL.
5. Offset 2094 with `x_center_mass`=1000 and `collision_in` on the same `new_frame` cycle → state HIT, offset 2094, DONE not entered.
6. Drop `rst_n_in` during HIT → all outputs are 0 without a clock edge. After release the state is IDLE and pulses do not move the offset.
